serial_addsub_with_vld: RTL and testbench

SERIAL_ADDSUB_WITH_VLD -- requirements
Module: serial_addsub_with_vld

---
 rtl/serial_arith_pkg.sv | 18 +
 rtl/serial_digit_addsub.sv | 26 ++
 rtl/serial_addsub_with_vld.sv | 171 +++++++++++++++++
 tb/tb_serial_addsub_with_vld.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types for the serial add/subtract datapath: FSM states and the latched operation.
package serial_arith_pkg;

   typedef enum logic {
      FIRST = 1'b0,
      MID   = 1'b1
   } state_e;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   function automatic op_e op_from_bit(input logic sub_bit);
      return sub_bit ? OP_SUB : OP_ADD;
   endfunction

endpackage

// File: rtl/serial_digit_addsub.sv
// One-digit ripple slice: a + (b ^ op) + cin, plus the carry into the MSB for signed overflow.
module serial_digit_addsub
   import serial_arith_pkg::*;
#(
   parameter int DIGIT_W = 4
) (
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  op_e                op,
   input  logic               cin,
   output logic [DIGIT_W-1:0] s,
   output logic               c_next,
   output logic               c_msb
);

   logic [DIGIT_W-1:0] b_x_s;
   logic [DIGIT_W:0]   full_s;

   assign b_x_s  = b ^ {DIGIT_W{op == OP_SUB}};
   assign full_s = {1'b0, a} + {1'b0, b_x_s} + {{DIGIT_W{1'b0}}, cin};
   assign s      = full_s[DIGIT_W-1:0];
   assign c_next = full_s[DIGIT_W];
   // Carry into the top bit is recovered from the top bit's own sum equation.
   assign c_msb  = full_s[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b_x_s[DIGIT_W-1];

endmodule

// File: rtl/serial_addsub_with_vld.sv
// LSB-first serial adder/subtractor with valid gating and forced word end at MAX_DIGITS.
// Define SERIAL_ADDSUB_OVERFLOW_EN to generate the registered signed-overflow flag.
module serial_addsub_with_vld
   import serial_arith_pkg::*;
#(
   parameter int DIGIT_W    = 4,
   parameter int MAX_DIGITS = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vld,
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               sub,
   input  logic               last,
   output logic [DIGIT_W-1:0] sum,
   output logic               sum_vld,
   output logic               sum_last,
   output logic               carry_out,
   output logic               len_err,
   output logic               overflow
);

   localparam int CNT_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_DIGITS - 1);

   state_e             state_q, state_d;
   op_e                op_q, op_d, op_s;
   logic               carry_q, carry_d, cin_s;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DIGIT_W-1:0] sum_q, sum_d, s_s;
   logic               sum_vld_q, sum_vld_d;
   logic               sum_last_q, sum_last_d;
   logic               carry_out_q, carry_out_d;
   logic               len_err_q, len_err_d;
   logic               c_next_s, word_end_s;

`ifdef SERIAL_ADDSUB_OVERFLOW_EN
   logic c_msb_s;

   serial_digit_addsub #(.DIGIT_W(DIGIT_W)) u_digit (
      .a      (a),
      .b      (b),
      .op     (op_s),
      .cin    (cin_s),
      .s      (s_s),
      .c_next (c_next_s),
      .c_msb  (c_msb_s)
   );
`else
   logic c_msb_unused_s;

   serial_digit_addsub #(.DIGIT_W(DIGIT_W)) u_digit (
      .a      (a),
      .b      (b),
      .op     (op_s),
      .cin    (cin_s),
      .s      (s_s),
      .c_next (c_next_s),
      .c_msb  (c_msb_unused_s)
   );
`endif

   // Operand/carry selection and next-state: sub is only consulted on a word's first digit.
   always_comb begin
      op_s        = op_q;
      cin_s       = carry_q;
      state_d     = state_q;
      op_d        = op_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      sum_vld_d   = 1'b0;
      sum_last_d  = 1'b0;
      carry_out_d = 1'b0;
      len_err_d   = 1'b0;
      case (state_q)
         FIRST: begin
            op_s  = op_from_bit(sub);
            cin_s = sub;
         end
         MID: begin
            op_s  = op_q;
            cin_s = carry_q;
         end
         default: begin
            op_s  = op_from_bit(sub);
            cin_s = sub;
         end
      endcase
      word_end_s = vld && (last || (cnt_q == CNT_LAST));
      if (vld) begin
         op_d      = op_s;
         sum_d     = s_s;
         sum_vld_d = 1'b1;
         if (word_end_s) begin
            state_d     = FIRST;
            carry_d     = 1'b0;
            cnt_d       = {CNT_W{1'b0}};
            sum_last_d  = 1'b1;
            carry_out_d = c_next_s;
            len_err_d   = !last;
         end else begin
            state_d = MID;
            carry_d = c_next_s;
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FIRST;
         op_q        <= OP_ADD;
         carry_q     <= 1'b0;
         cnt_q       <= {CNT_W{1'b0}};
         sum_q       <= {DIGIT_W{1'b0}};
         sum_vld_q   <= 1'b0;
         sum_last_q  <= 1'b0;
         carry_out_q <= 1'b0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         sum_vld_q   <= sum_vld_d;
         sum_last_q  <= sum_last_d;
         carry_out_q <= carry_out_d;
         len_err_q   <= len_err_d;
      end
   end

`ifdef SERIAL_ADDSUB_OVERFLOW_EN
   logic overflow_q, overflow_d;

   // Signed overflow of the whole word, judged on its final digit.
   always_comb begin
      overflow_d = 1'b0;
      if (word_end_s) begin
         overflow_d = c_msb_s ^ c_next_s;
      end else begin
         overflow_d = 1'b0;
      end
   end

   // Overflow register, aligned with sum_last.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;
`else
   assign overflow = 1'b0;
`endif

   assign sum       = sum_q;
   assign sum_vld   = sum_vld_q;
   assign sum_last  = sum_last_q;
   assign carry_out = carry_out_q;
   assign len_err   = len_err_q;

endmodule

// File: tb/tb_serial_addsub_with_vld.sv
// Bench for serial_addsub_with_vld (DIGIT_W=4, MAX_DIGITS=4); expected results come from
// whole-word integer arithmetic on the digits received so far.
module tb_serial_addsub_with_vld;

   localparam int MAXD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vld = 1'b0;
   logic [3:0] a = 4'h0;
   logic [3:0] b = 4'h0;
   logic       sub = 1'b0;
   logic       last = 1'b0;
   logic [3:0] sum;
   logic       sum_vld, sum_last, carry_out, len_err, overflow;

   int n_vec = 0;
   int n_err = 0;

   serial_addsub_with_vld #(.DIGIT_W(4), .MAX_DIGITS(MAXD)) dut (
      .clk       (clk),
      .rst       (rst),
      .vld       (vld),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .last      (last),
      .sum       (sum),
      .sum_vld   (sum_vld),
      .sum_last  (sum_last),
      .carry_out (carry_out),
      .len_err   (len_err),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   logic [8:0] dut_o;
   assign dut_o = {sum, sum_vld, sum_last, carry_out, len_err, overflow};

   bit         m_in_word = 1'b0;
   bit         m_op = 1'b0;
   int         m_n = 0;
   longint     m_a = 0, m_b = 0;
   logic [3:0] e_sum = 4'h0;
   bit         e_vld = 1'b0, e_last = 1'b0, e_cout = 1'b0, e_len = 1'b0, e_ovf = 1'b0;
   logic [8:0] exp_o = 9'h0;
`ifdef SERIAL_ADDSUB_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   // Drive one cycle, then advance the word-level reference to what the outputs must show.
   task automatic step(input bit r, input bit v, input bit [3:0] av, input bit [3:0] bv,
                       input bit sv, input bit lv);
      longint modw, tot, sa, sb, sr;
      bit     wend;
      rst = r; vld = v; a = av; b = bv; sub = sv; last = lv;
      @(posedge clk);
      if (r) begin
         m_in_word = 1'b0;
         e_sum = 4'h0; e_vld = 1'b0; e_last = 1'b0; e_cout = 1'b0; e_len = 1'b0; e_ovf = 1'b0;
      end else if (v) begin
         if (!m_in_word) begin
            m_op = sv; m_n = 0; m_a = 0; m_b = 0;
         end
         m_a  = m_a + (longint'(av) << (4 * m_n));
         m_b  = m_b + (longint'(bv) << (4 * m_n));
         m_n  = m_n + 1;
         modw = 64'sd1 <<< (4 * m_n);
         tot  = m_op ? (m_a + (modw - m_b)) : (m_a + m_b);
         wend = lv || (m_n == MAXD);
         sa   = (m_a >= modw / 2) ? m_a - modw : m_a;
         sb   = (m_b >= modw / 2) ? m_b - modw : m_b;
         sr   = m_op ? sa - sb : sa + sb;
         e_sum  = 4'((tot >> (4 * (m_n - 1))) & 64'd15);
         e_vld  = 1'b1;
         e_last = wend;
         e_cout = wend && (((tot >> (4 * m_n)) & 64'd1) != 0);
         e_len  = wend && !lv;
         e_ovf  = OVF_EN && wend && ((sr < -(modw / 2)) || (sr >= modw / 2));
         m_in_word = !wend;
      end else begin
         e_vld = 1'b0; e_last = 1'b0; e_cout = 1'b0; e_len = 1'b0; e_ovf = 1'b0;
      end
      exp_o = {e_sum, e_vld, e_last, e_cout, e_len, e_ovf};
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1);
         n_vec++;
         if (dut_o !== 9'h000) begin
            n_err++; $display("FAIL reset: got %b want %b", dut_o, 9'h000);
         end
      end
   endtask

   task automatic test_add();
      bit [3:0] av[2] = '{4'h5, 4'h3};
      bit [3:0] bv[2] = '{4'hA, 4'h2};
      bit [3:0] want[2] = '{4'hF, 4'h5};
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, av[i], bv[i], i[0], i[0]);
         n_vec += 2;
         if (dut_o !== exp_o) begin
            n_err++; $display("FAIL add digit%0d: got %b want %b", i, dut_o, exp_o);
         end
         if (sum !== want[i] || sum_last !== i[0]) begin
            n_err++; $display("FAIL add_lit digit%0d: got sum %h last %b want %h %b",
                              i, sum, sum_last, want[i], i[0]);
         end
      end
      n_vec++;
      if (carry_out !== 1'b0) begin
         n_err++; $display("FAIL add_cout: got %b want 0", carry_out);
      end
   endtask

   task automatic test_sub();
      bit [3:0] av[2] = '{4'h0, 4'h3};
      bit [3:0] bv[2] = '{4'h1, 4'h0};
      bit [3:0] want[2] = '{4'hF, 4'h2};
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, av[i], bv[i], !i[0], i[0]);
         n_vec += 2;
         if (dut_o !== exp_o) begin
            n_err++; $display("FAIL sub digit%0d: got %b want %b", i, dut_o, exp_o);
         end
         if (sum !== want[i]) begin
            n_err++; $display("FAIL sub_lit digit%0d: got %h want %h", i, sum, want[i]);
         end
      end
      n_vec++;
      if (carry_out !== 1'b1 || sum_last !== 1'b1) begin
         n_err++; $display("FAIL sub_cout: got %b/%b want 1/1", carry_out, sum_last);
      end
   endtask

   task automatic test_gaps();
      step(1'b0, 1'b1, 4'h5, 4'hA, 1'b0, 1'b0);
      n_vec++;
      if (dut_o !== exp_o) begin
         n_err++; $display("FAIL gap first: got %b want %b", dut_o, exp_o);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 4'(i), 4'(i + 7), 1'b1, 1'b1);
         n_vec++;
         if (dut_o !== exp_o || sum_vld !== 1'b0 || sum_last !== 1'b0) begin
            n_err++; $display("FAIL gap idle%0d: got %b want %b", i, dut_o, exp_o);
         end
      end
      step(1'b0, 1'b1, 4'h3, 4'h2, 1'b0, 1'b1);
      n_vec++;
      if (dut_o !== exp_o || sum !== 4'h5 || carry_out !== 1'b0 || sum_last !== 1'b1) begin
         n_err++; $display("FAIL gap last: got %b want %b", dut_o, exp_o);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0);
      step(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b1);
      n_vec++;
      if (dut_o !== exp_o || sum_last !== 1'b0) begin
         n_err++; $display("FAIL rst_mid flush: got %b want %b", dut_o, exp_o);
      end
      step(1'b0, 1'b1, 4'h1, 4'h1, 1'b0, 1'b1);
      n_vec++;
      if (dut_o !== exp_o || sum !== 4'h2 || carry_out !== 1'b0) begin
         n_err++; $display("FAIL rst_mid word: got %b want %b", dut_o, exp_o);
      end
   endtask

   task automatic test_len_err();
      for (int i = 0; i < 5; i++) begin
         if (i == 4) step(1'b0, 1'b1, 4'h2, 4'h1, 1'b1, 1'b0);
         else        step(1'b0, 1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), i[0], 1'b0);
         n_vec++;
         if (dut_o !== exp_o) begin
            n_err++; $display("FAIL len digit%0d: got %b want %b", i, dut_o, exp_o);
         end
      end
      n_vec++;
      if (sum !== 4'h1 || sum_last !== 1'b0 || len_err !== 1'b0) begin
         n_err++; $display("FAIL len newword: got sum %h last %b err %b want 1 0 0",
                           sum, sum_last, len_err);
      end
      step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1);
      n_vec++;
      if (dut_o !== exp_o || len_err !== 1'b0) begin
         n_err++; $display("FAIL len close: got %b want %b", dut_o, exp_o);
      end
   endtask

   task automatic test_len_flag();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0);
      end
      n_vec++;
      if (len_err !== 1'b1 || sum_last !== 1'b1 || sum !== 4'h2) begin
         n_err++; $display("FAIL len_flag: got err %b last %b sum %h want 1 1 2",
                           len_err, sum_last, sum);
      end
   endtask

   task automatic test_overflow();
      step(1'b0, 1'b1, 4'h7, 4'h1, 1'b0, 1'b1);
      n_vec++;
      if (dut_o !== exp_o || sum !== 4'h8 || carry_out !== 1'b0 || overflow !== OVF_EN) begin
         n_err++; $display("FAIL overflow: got %b want %b (ovf want %b)", dut_o, exp_o, OVF_EN);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(99) < 2, $urandom_range(99) < 75, 4'($urandom_range(15)),
              4'($urandom_range(15)), 1'($urandom_range(1)), $urandom_range(99) < 30);
         n_vec++;
         if (dut_o !== exp_o) begin
            n_err++; $display("FAIL random step%0d: got %b want %b", i, dut_o, exp_o);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         step(1'b0, 1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)),
              1'($urandom_range(1)), $urandom_range(99) < 40);
         n_vec++;
         if (dut_o !== exp_o) begin
            n_err++; $display("FAIL b2b step%0d: got %b want %b", i, dut_o, exp_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_gaps();
      test_reset_mid();
      test_len_err();
      test_len_flag();
      test_overflow();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
